// File: rtl/ccff_bitstream_loader_if.sv
// rtl/ccff_bitstream_loader_if.sv - bitstream word stream into the configuration-chain loader
// Ports (per modport):
//    master : drives word_in, word_valid; samples word_ready
//    slave  : samples word_in, word_valid; drives word_ready
// A word transfers on any prog_clk edge where word_valid && word_ready.
interface ccff_bitstream_loader_if #(
   parameter int WORD_W = 32
) ();
   logic [WORD_W-1:0] word_in;
   logic              word_valid;
   logic              word_ready;

   modport master (output word_in, output word_valid, input word_ready);
   modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - serialises a preamble plus bitstream words onto ccff_head and checks ccff_tail
// Ports:
//    prog_clk, prog_reset : clock, asynchronous active-high reset
//    start, abort         : begin a load when idle / cancel a load in progress
//    stream               : word stream (slave); MSB of each word leaves first
//    ccff_head            : serial data into the configuration chain
//    prog_clk_en          : chain shifts at the end of each cycle in which this is 1
//    ccff_tail            : chain output, compared with the preamble during the last TAG_W shifts
//    busy, done, error    : load in progress / one-cycle completion pulse / sticky preamble mismatch
module ccff_bitstream_loader #(
   parameter int              WORD_W    = 32,
   parameter int              CHAIN_LEN = 4096,
   parameter int              TAG_W     = 8,
   parameter logic [TAG_W-1:0] PREAMBLE = TAG_W'(8'hA5),
   parameter int              CNT_W     = $clog2(CHAIN_LEN + TAG_W + 1)
) (
   input  logic                  prog_clk,
   input  logic                  prog_reset,
   input  logic                  start,
   input  logic                  abort,
   ccff_bitstream_loader_if.slave stream,
   output logic                  ccff_head,
   output logic                  prog_clk_en,
   input  logic                  ccff_tail,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int WORDS     = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int LAST_BITS = CHAIN_LEN - (WORDS - 1) * WORD_W;
   localparam int BC_W      = $clog2(WORD_W + 1);
   localparam int WC_W      = $clog2(WORDS + 1);

   typedef enum logic [1:0] {IDLE, PRE, SHIFT, DONE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  n;          // shifts performed in this load
   logic [WORD_W-1:0] shreg;      // one-word bit buffer, MSB is the next bit out
   logic [BC_W-1:0]   bit_cnt;    // valid bits left in shreg
   logic [WC_W-1:0]   word_cnt;   // words accepted in this load
   logic [TAG_W-1:0]  tag_sr;     // preamble being sent, then the pattern expected back

   logic shift, head, ready, accept, check, start_load, more_words;

   assign more_words = (word_cnt != WC_W'(WORDS));
   assign start_load = (state == IDLE) && start && !abort;
   assign accept     = ready && stream.word_valid;
   // Only the final TAG_W shifts carry the preamble back out of the chain.
   assign check      = (state == SHIFT) && shift && (n >= CNT_W'(CHAIN_LEN));

   always_comb begin
      state_nxt = state;
      shift     = 1'b0;
      head      = 1'b0;
      ready     = 1'b0;
      case (state)
         IDLE: begin
            if (start_load) state_nxt = PRE;
         end
         PRE: begin
            shift = 1'b1;
            head  = tag_sr[TAG_W-1];
            // Prefetching the first word here removes any bubble after the preamble.
            ready = (bit_cnt == '0) && more_words;
            if (n == CNT_W'(TAG_W - 1)) state_nxt = SHIFT;
            if (abort) state_nxt = IDLE;
         end
         SHIFT: begin
            shift = (bit_cnt != '0);
            head  = shift && shreg[WORD_W-1];
            // Refill while the last buffered bit is leaving so words stream back to back.
            ready = more_words && (bit_cnt <= BC_W'(1));
            if (shift && (n == CNT_W'(CHAIN_LEN + TAG_W - 1))) state_nxt = DONE;
            if (abort) state_nxt = IDLE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         state    <= IDLE;
         n        <= '0;
         shreg    <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
         tag_sr   <= '0;
         error    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start_load) begin
            n        <= '0;
            error    <= 1'b0;
            tag_sr   <= PREAMBLE;
            bit_cnt  <= '0;
            word_cnt <= '0;
         end else begin
            if (shift) n <= n + 1'b1;
            if (check && (ccff_tail != tag_sr[TAG_W-1])) error <= 1'b1;
            if (state == PRE) begin
               // Reload after the last preamble bit so the same register checks the tail.
               tag_sr <= (n == CNT_W'(TAG_W - 1)) ? PREAMBLE : {tag_sr[TAG_W-2:0], 1'b0};
            end else if (check) begin
               tag_sr <= {tag_sr[TAG_W-2:0], 1'b0};
            end
            if (busy && abort) begin
               bit_cnt <= '0;
            end else if (accept) begin
               shreg    <= stream.word_in;
               // The final word only contributes the bits that still fit in the chain.
               bit_cnt  <= (word_cnt == WC_W'(WORDS - 1)) ? BC_W'(LAST_BITS) : BC_W'(WORD_W);
               word_cnt <= word_cnt + 1'b1;
            end else if ((state == SHIFT) && shift) begin
               shreg   <= {shreg[WORD_W-2:0], 1'b0};
               bit_cnt <= bit_cnt - 1'b1;
            end
         end
      end
   end

   assign stream.word_ready = ready;
   assign prog_clk_en       = shift;
   assign ccff_head         = head;
   assign busy              = (state == PRE) || (state == SHIFT);
   assign done              = (state == DONE);

endmodule
